// File: rtl/trap_controller.sv
// Trap/mret sequencer: IDLE -> SAVE -> REDIRECT -> FLUSH -> IDLE, or IDLE -> MRET_RET -> FLUSH -> IDLE.
// Define TRAP_EXT_IRQ_EN to let an enabled external interrupt enter the trap path from IDLE.
module trap_controller #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            invalid_inst,
    input  logic            mret,
    input  logic            stall,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            ext_irq,
    input  logic            mstatus_mie,
    output logic            clear_invalid_counter,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            mepc_we,
    output logic            mcause_we,
    output logic            mtval_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic [XLEN-1:0] mcause_wdata,
    output logic [XLEN-1:0] mtval_wdata,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic            trap_taken,
    output logic            busy
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [XLEN-1:0] ILLEGAL_CAUSE = XLEN'(2);
    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(11)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_REDIRECT,
        S_MRET_RET,
        S_FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              irq_req;
    logic [XLEN-1:0]   trap_target;

`ifdef TRAP_EXT_IRQ_EN
    assign irq_req = ext_irq & mstatus_mie;
    // Vectored mode only offsets interrupts; synchronous exceptions always land on the base.
    assign trap_target = {csr_mtvec[XLEN-1:2], 2'b00}
                       + ((csr_mtvec[1:0] == 2'b01 && cause_q[XLEN-1]) ? XLEN'(44) : XLEN'(0));
`else
    logic unused_irq;
    assign unused_irq  = ^{ext_irq, mstatus_mie, csr_mtvec[1:0]};
    assign irq_req     = 1'b0;
    assign trap_target = {csr_mtvec[XLEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            tval_q   <= '0;
            cause_q  <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tval_q   <= tval_d;
            cause_q  <= cause_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tval_d   = tval_q;
        cause_d  = cause_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!stall) begin
                    if (invalid_inst) begin
                        pc_d    = id_pc;
                        tval_d  = XLEN'(id_inst);
                        cause_d = ILLEGAL_CAUSE;
                        state_d = S_SAVE;
                    end else if (mret) begin
                        target_d = csr_mepc;
                        state_d  = S_MRET_RET;
                    end else if (irq_req) begin
                        pc_d    = id_pc;
                        tval_d  = '0;
                        cause_d = IRQ_CAUSE;
                        state_d = S_SAVE;
                    end
                end
            end
            S_SAVE: begin
                target_d = trap_target;
                state_d  = S_REDIRECT;
            end
            S_REDIRECT, S_MRET_RET: begin
                if (!stall) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Data outputs are gated to zero outside their strobe so reset leaves every output at 0.
    always_comb begin
        clear_invalid_counter = 1'b0;
        pc_redirect           = 1'b0;
        redirect_pc           = '0;
        flush_if_id           = 1'b0;
        flush_id_ex           = 1'b0;
        mepc_we               = 1'b0;
        mcause_we             = 1'b0;
        mtval_we              = 1'b0;
        mepc_wdata            = '0;
        mcause_wdata          = '0;
        mtval_wdata           = '0;
        mstatus_trap          = 1'b0;
        mstatus_mret          = 1'b0;
        trap_taken            = 1'b0;
        busy                  = (state_q != S_IDLE);
        case (state_q)
            S_SAVE: begin
                mepc_we      = 1'b1;
                mcause_we    = 1'b1;
                mtval_we     = 1'b1;
                mepc_wdata   = pc_q;
                mcause_wdata = cause_q;
                mtval_wdata  = tval_q;
                mstatus_trap = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
            end
            S_REDIRECT: begin
                pc_redirect           = 1'b1;
                redirect_pc           = target_q;
                flush_if_id           = 1'b1;
                flush_id_ex           = 1'b1;
                trap_taken            = ~stall;
                clear_invalid_counter = ~stall;
            end
            S_MRET_RET: begin
                pc_redirect           = 1'b1;
                redirect_pc           = target_q;
                flush_if_id           = 1'b1;
                flush_id_ex           = 1'b1;
                mstatus_mret          = ~stall;
                clear_invalid_counter = ~stall;
            end
            S_FLUSH: begin
                flush_if_id = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Randomized bench for trap_controller; expected behaviour comes from a phase-level model of the trap/mret sequence.
module tb_trap_controller;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            invalid_inst, mret, stall, ext_irq, mstatus_mie;
    logic [XLEN-1:0] id_pc, csr_mtvec, csr_mepc;
    logic [31:0]     id_inst;

    logic            clear_invalid_counter, pc_redirect, flush_if_id, flush_id_ex;
    logic            mepc_we, mcause_we, mtval_we, mstatus_trap, mstatus_mret, trap_taken, busy;
    logic [XLEN-1:0] redirect_pc, mepc_wdata, mcause_wdata, mtval_wdata;

    logic            z_clr, z_pcr, z_fif, z_fie, z_mepc_we, z_mcause_we, z_mtval_we;
    logic            z_mst_trap, z_mst_mret, z_trap_taken, z_busy;
    logic [XLEN-1:0] z_rpc, z_mepc_wd, z_mcause_wd, z_mtval_wd;

    trap_controller #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset_n(reset_n), .invalid_inst(invalid_inst), .mret(mret), .stall(stall),
        .id_pc(id_pc), .id_inst(id_inst), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .clear_invalid_counter(clear_invalid_counter), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .mepc_we(mepc_we), .mcause_we(mcause_we), .mtval_we(mtval_we),
        .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .mtval_wdata(mtval_wdata),
        .mstatus_trap(mstatus_trap), .mstatus_mret(mstatus_mret), .trap_taken(trap_taken),
        .busy(busy)
    );

    // Same stimulus, no flush tail: must be back in IDLE the cycle after the redirect exits.
    trap_controller #(.XLEN(XLEN), .FLUSH_CYCLES(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .invalid_inst(invalid_inst), .mret(mret), .stall(stall),
        .id_pc(id_pc), .id_inst(id_inst), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .clear_invalid_counter(z_clr), .pc_redirect(z_pcr),
        .redirect_pc(z_rpc), .flush_if_id(z_fif), .flush_id_ex(z_fie),
        .mepc_we(z_mepc_we), .mcause_we(z_mcause_we), .mtval_we(z_mtval_we),
        .mepc_wdata(z_mepc_wd), .mcause_wdata(z_mcause_wd), .mtval_wdata(z_mtval_wd),
        .mstatus_trap(z_mst_trap), .mstatus_mret(z_mst_mret), .trap_taken(z_trap_taken),
        .busy(z_busy)
    );

    wire [10:0] flags = {busy, pc_redirect, flush_if_id, flush_id_ex, mepc_we, mcause_we,
                         mtval_we, mstatus_trap, mstatus_mret, trap_taken, clear_invalid_counter};

    typedef enum int {P_IDLE, P_SAVE, P_TRAP_REDIR, P_MRET_REDIR, P_FLUSH} phase_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control flags for a phase of the sequence, straight from the behavioural rules.
    function automatic logic [10:0] expf(input phase_t p, input bit exit_cycle);
        bit redir, save;
        redir = (p == P_TRAP_REDIR) || (p == P_MRET_REDIR);
        save  = (p == P_SAVE);
        return {p != P_IDLE, redir, p != P_IDLE, save | redir, save, save, save, save,
                (p == P_MRET_REDIR) && exit_cycle, (p == P_TRAP_REDIR) && exit_cycle,
                redir && exit_cycle};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        invalid_inst = 1'b0;
        mret         = 1'b0;
        ext_irq      = 1'b0;
    endtask

    task automatic redirect_and_flush(input phase_t p, input logic [XLEN-1:0] tgt, input int k);
        for (int i = 0; i <= k; i++) begin
            invalid_inst = 1'($urandom_range(0, 1));
            mret         = 1'($urandom_range(0, 1));
            stall        = (i < k);
            @(negedge clk);
            check("redir_flags", flags, expf(p, i == k));
            check("redirect_pc", redirect_pc, tgt);
            check("nf_busy_redir", z_busy, 1);
            tick();
        end
        clear_events();
        for (int i = 0; i < FC; i++) begin
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("flush_flags", flags, expf(P_FLUSH, 0));
            if (i == 0) check("nf_idle_after_redir", z_busy, 0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        check("back_idle", flags, expf(P_IDLE, 0));
        check("nf_back_idle", z_busy, 0);
        tick();
    endtask

    task automatic do_trap(input bit irq, input logic [XLEN-1:0] pc, input logic [31:0] inst,
                           input logic [XLEN-1:0] mtvec, input int k, input bit with_mret);
        logic [XLEN-1:0] e_cause, e_tval, e_tgt;
        e_cause = irq ? 32'h8000_000B : 32'd2;
        e_tval  = irq ? 32'd0 : inst;
        e_tgt   = {mtvec[XLEN-1:2], 2'b00} + ((irq && mtvec[1:0] == 2'b01) ? 32'd44 : 32'd0);
        id_pc = pc; id_inst = inst; csr_mtvec = mtvec; stall = 1'b0;
        if (irq) begin
            ext_irq = 1'b1; mstatus_mie = 1'b1;
        end else begin
            invalid_inst = 1'b1; mret = with_mret;
        end
        @(negedge clk);
        check("pre_idle", flags, expf(P_IDLE, 0));
        tick();
        clear_events();
        invalid_inst = 1'($urandom_range(0, 1));
        stall = 1'($urandom_range(0, 1));
        id_pc = $urandom; id_inst = $urandom;
        @(negedge clk);
        check("save_flags", flags, expf(P_SAVE, 0));
        check("mepc_wdata", mepc_wdata, pc);
        check("mcause_wdata", mcause_wdata, e_cause);
        check("mtval_wdata", mtval_wdata, e_tval);
        tick();
        redirect_and_flush(P_TRAP_REDIR, e_tgt, k);
    endtask

    task automatic do_mret(input logic [XLEN-1:0] mepc, input int k);
        csr_mepc = mepc; mret = 1'b1; stall = 1'b0;
        @(negedge clk);
        check("pre_idle_mret", flags, expf(P_IDLE, 0));
        tick();
        redirect_and_flush(P_MRET_REDIR, mepc, k);
    endtask

    task automatic stalled_event();
        invalid_inst = 1'($urandom_range(0, 1));
        mret = ~invalid_inst;
        stall = 1'b1;
        @(negedge clk);
        tick();
        clear_events(); stall = 1'b0;
        @(negedge clk);
        check("stalled_no_event", flags, expf(P_IDLE, 0));
        tick();
    endtask

    task automatic irq_probe(input bit mie, input bit expect_trap);
        ext_irq = 1'b1; mstatus_mie = mie; stall = 1'b0;
        @(negedge clk);
        tick();
        clear_events();
        @(negedge clk);
        check("irq_probe", flags, expf(expect_trap ? P_SAVE : P_IDLE, 0));
        tick();
    endtask

    task automatic reset_mid_save();
        id_pc = 32'h444; id_inst = 32'hDEAD_BEEF; csr_mtvec = 32'h80; invalid_inst = 1'b1; stall = 1'b0;
        tick();
        clear_events();
        reset_n = 1'b0;
        #1;
        check("rst_flags", flags, 0);
        check("rst_mepc_wdata", mepc_wdata, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", flags, 0);
        check("post_rst_mcause", mcause_wdata, 0);
        tick();
    endtask

    initial begin
        clear_events();
        stall = 1'b0; mstatus_mie = 1'b0;
        id_pc = '0; id_inst = '0; csr_mtvec = '0; csr_mepc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", flags, 0);
        check("reset_redirect_pc", redirect_pc, 0);
        reset_n = 1'b1;
        tick();

        do_trap(0, 32'h100, 32'hFFFF_FFFF, 32'h80, 0, 0);
        do_mret(32'h104, 0);
        stalled_event();
        do_trap(0, 32'h200, 32'h1234_5678, 32'h80, 3, 1);
        reset_mid_save();
`ifdef TRAP_EXT_IRQ_EN
        do_trap(1, 32'h300, 32'h0, 32'h201, 0, 0);
        irq_probe(0, 0);
`else
        irq_probe(1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    do_trap(0, $urandom & ~32'h1, $urandom, $urandom, $urandom_range(0, 3),
                                 1'($urandom_range(0, 1)));
                2:       do_mret($urandom, $urandom_range(0, 3));
                default: stalled_event();
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
